eth_tx_fcs_ctrl: RTL and testbench
==================================

# eth_tx_fcs_ctrl

Transmit-side frame sequencer for the Ethernet MAC. It accepts a payload byte stream from the MAC TX path and drives the per-byte CRC-32 update. It pads short frames to the minimum Ethernet length, then appends the 4-byte FCS and marks the last byte. It sits between the TX frame buffer and the PHY-side byte serializer.

## Interface
- `MIN_FRAME`, default 60: minimum frame length in bytes, excluding FCS; used only when padding is compiled in.
- `MAX_FRAME`, default 1514: maximum frame length in bytes, excluding FCS; longer frames raise `oversize_err`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_data`  in  `global::datalen`  payload byte.
- `s_valid`  in  1  payload byte valid.
- `s_last`  in  1  marks the final payload byte of a frame.
- `s_ready`  out  1  payload byte accepted when `s_valid && s_ready`.
- `m_data`  out  `global::datalen`  output byte: payload, pad, or FCS.
- `m_valid`  out  1  output byte valid.
- `m_last`  out  1  marks the final FCS byte.
- `m_ready`  in  1  downstream accepts when `m_valid && m_ready`.
- `frame_done`  out  1  one-cycle pulse when the last FCS byte is accepted.
- `oversize_err`  out  1  one-cycle pulse, coincident with `frame_done`, if the payload exceeded `MAX_FRAME`.
- `byte_cnt`  out  12  bytes emitted in the current frame, excluding FCS.

## Operation
- States:
  - IDLE → DATA when `s_valid`.
  - DATA → PAD on an accepted `s_last` when padding is enabled and `byte_cnt` after the increment is below `MIN_FRAME`.
  - DATA → FCS on any other accepted `s_last`.
  - PAD → FCS when the pad byte that brings `byte_cnt` to `MIN_FRAME` is accepted.
  - FCS → IDLE when the 4th FCS byte is accepted.
- CRC-32, IEEE 802.3:
  - Accumulator initialises to 0xFFFFFFFF at the start of every frame.
  - Polynomial 0x04C11DB7; each byte is bit-reflected before it is folded in.
  - Every payload and pad byte updates the accumulator; FCS bytes do not.
  - FCS = ~reflect32(acc), sent least-significant byte first.
- `s_ready` = (state==DATA) && (!`m_valid` || `m_ready`). It is 0 in IDLE, PAD and FCS.
- Output is a single register stage. A new byte loads only when the stage is empty or being drained in the same cycle.
- Pad bytes are 0x00.
- `byte_cnt` saturates at 4095. An error flag is set when `byte_cnt` exceeds `MAX_FRAME`; it is reported and cleared at `frame_done`. Oversize frames are still transmitted in full.
- A 1-byte frame (`s_last` on the first byte) is legal.

## Timing
- Reset values:
  - `m_valid`, `m_last`, `frame_done`, `oversize_err`, `s_ready` = 0.
  - `m_data` = 0x00, `byte_cnt` = 0.
  - State = IDLE, CRC accumulator = 0xFFFFFFFF.
- Latency: an accepted input byte appears on `m_data` the next cycle.
- The first pad byte or first FCS byte is presented the cycle after the last payload byte is accepted into the output stage.
- Under continuous `m_ready`, a frame of N payload bytes occupies exactly max(N, MIN_FRAME) + 4 output cycles, back to back.
- The FCS for the final data or pad byte must already be correct when the first FCS byte loads. The CRC update is combinational into the accumulator register.
- `m_ready` low holds `m_data`, `m_valid` and `m_last` stable. While held, no CRC update and no count change occur.
- `rst` mid-frame: the next cycle is IDLE with outputs at reset values. The partial frame is abandoned and no FCS is emitted.
- After `frame_done`, the next frame may begin in the following cycle. There is no inter-frame gap; gap insertion is the serializer's job.

## Configuration
- `ETH_TX_PAD_EN`:
  - Defined: short frames are padded with 0x00 up to `MIN_FRAME` before the FCS.
  - Undefined: the PAD state is absent; DATA always goes to FCS, and frames shorter than `MIN_FRAME` are sent unpadded.

## Structure
- Package `global` holds the state enum type, `crc_poly` (0x04C11DB7), `crc_len`, `datalen`, and the reflect/step functions.
- One natural sub-module, `crc32_byte_step`: a combinational 32-bit accumulator plus one byte in, next accumulator out. The controller owns the accumulator register.

## Test plan
- ASCII "123456789" with `MIN_FRAME`=0 or pad disabled → 9 bytes passed through, then 0x26 0x39 0xF4 0xCB with `m_last` on 0xCB; `frame_done` pulses once.
- 14-byte frame with pad enabled → 46 bytes of 0x00 follow the payload; `byte_cnt` reaches 60; the FCS equals the reference CRC over all 60 bytes.
- 1515-byte frame → all bytes plus FCS emitted; `oversize_err` pulses with `frame_done`.
- Random `m_ready` deassertion during DATA, PAD and FCS → output identical to the no-stall run, with no duplicated or dropped bytes.
- `rst` asserted on payload byte 20 → next cycle IDLE, `m_valid`=0; the following "123456789" frame still yields FCS 0xCBF43926.
- Two frames back to back with `s_valid` held high → the second frame's first byte is accepted the cycle after the first frame's `frame_done`.

Source files
------------

// File: rtl/eth_tx_fcs_ctrl_pkg.sv
// eth_tx_fcs_ctrl_pkg: shared types, CRC-32 constants and bit-reflect / byte-step helpers.
// Contents: state_t (FSM encoding), datalen, crc_len, crc_poly, crc_init,
//           reflect8, reflect32 and crc_step (one MSB-first CRC-32 byte update).
package eth_tx_fcs_ctrl_pkg;

    localparam int datalen = 8;
    localparam int crc_len = 32;
    localparam logic [crc_len-1:0] crc_poly = 32'h04C1_1DB7;
    localparam logic [crc_len-1:0] crc_init = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAD,
        ST_FCS
    } state_t;

    function automatic logic [datalen-1:0] reflect8(input logic [datalen-1:0] b);
        logic [datalen-1:0] r;
        for (int i = 0; i < datalen; i++) r[i] = b[datalen-1-i];
        return r;
    endfunction

    function automatic logic [crc_len-1:0] reflect32(input logic [crc_len-1:0] v);
        logic [crc_len-1:0] r;
        for (int i = 0; i < crc_len; i++) r[i] = v[crc_len-1-i];
        return r;
    endfunction

    // Ethernet sends bytes LSB first, so each byte is reflected before the MSB-first fold.
    function automatic logic [crc_len-1:0] crc_step(input logic [crc_len-1:0] acc,
                                                    input logic [datalen-1:0] b);
        logic [crc_len-1:0] c;
        c = acc ^ {reflect8(b), 24'h0};
        for (int i = 0; i < datalen; i++) c = c[crc_len-1] ? ((c << 1) ^ crc_poly) : (c << 1);
        return c;
    endfunction

endpackage

// File: rtl/eth_tx_fcs_ctrl_crc32_byte_step.sv
// eth_tx_fcs_ctrl_crc32_byte_step: combinational CRC-32 update of a 32-bit accumulator by one byte.
// Ports: crc_in (current accumulator), data (byte to fold in), crc_out (next accumulator).
module eth_tx_fcs_ctrl_crc32_byte_step
    import eth_tx_fcs_ctrl_pkg::*;
(
    input  logic [crc_len-1:0] crc_in,
    input  logic [datalen-1:0] data,
    output logic [crc_len-1:0] crc_out
);

    assign crc_out = crc_step(crc_in, data);

endmodule

// File: rtl/eth_tx_fcs_ctrl.sv
// eth_tx_fcs_ctrl: TX frame sequencer -- passes payload, pads short frames, appends CRC-32 FCS.
// Parameters: MIN_FRAME (pad target, bytes excl. FCS), MAX_FRAME (oversize threshold).
// Build option: define ETH_TX_PAD_EN to enable zero padding up to MIN_FRAME.
// Ports: clk, rst (sync, active high);
//        s_data/s_valid/s_last/s_ready  payload stream in;
//        m_data/m_valid/m_last/m_ready  byte stream out (m_last on final FCS byte);
//        frame_done   one-cycle pulse after the last FCS byte is accepted;
//        oversize_err one-cycle pulse with frame_done when payload exceeded MAX_FRAME;
//        byte_cnt     payload+pad bytes emitted in the current frame (saturates at 4095).
module eth_tx_fcs_ctrl
    import eth_tx_fcs_ctrl_pkg::*;
#(
    parameter int MIN_FRAME = 60,
    parameter int MAX_FRAME = 1514
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [datalen-1:0] s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [datalen-1:0] m_data,
    output logic               m_valid,
    output logic               m_last,
    input  logic               m_ready,
    output logic               frame_done,
    output logic               oversize_err,
    output logic [11:0]        byte_cnt
);

`ifdef ETH_TX_PAD_EN
    localparam logic pad_en = 1'b1;
`else
    localparam logic pad_en = 1'b0;
`endif
    localparam logic [11:0] min_c = (MIN_FRAME > 4095) ? 12'hFFF : 12'(MIN_FRAME);
    localparam logic [11:0] max_c = (MAX_FRAME > 4095) ? 12'hFFF : 12'(MAX_FRAME);

    state_t             state_q, state_d;
    logic [datalen-1:0] m_data_q, m_data_d;
    logic               m_valid_q, m_valid_d;
    logic               m_last_q, m_last_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic [11:0]        cnt_q, cnt_d;
    logic [crc_len-1:0] crc_q, crc_d;
    logic [1:0]         fcs_idx_q, fcs_idx_d;

    logic               load;
    logic [11:0]        cnt_inc;
    logic [datalen-1:0] byte_in;
    logic [crc_len-1:0] crc_next;
    logic [crc_len-1:0] fcs;
    logic [datalen-1:0] fcs_byte;

    // The output stage may take a new byte when empty or drained this cycle.
    assign load     = !m_valid_q || m_ready;
    assign s_ready  = (state_q == ST_DATA) && load;
    assign cnt_inc  = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1;
    assign byte_in  = (state_q == ST_PAD) ? '0 : s_data;
    assign fcs      = ~reflect32(crc_q);
    assign fcs_byte = fcs[{fcs_idx_q, 3'b000} +: datalen];

    eth_tx_fcs_ctrl_crc32_byte_step u_step (
        .crc_in  (crc_q),
        .data    (byte_in),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d   = state_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        fcs_idx_d = fcs_idx_q;
        done_d    = 1'b0;
        ovf_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                crc_d     = crc_init;
                err_d     = 1'b0;
                fcs_idx_d = '0;
                state_d   = s_valid ? ST_DATA : ST_IDLE;
            end
            ST_DATA: if (load) begin
                m_valid_d = s_valid;
                m_last_d  = 1'b0;
                if (s_valid) begin
                    m_data_d = s_data;
                    crc_d    = crc_next;
                    cnt_d    = cnt_inc;
                    err_d    = err_q || (cnt_inc > max_c);
                    // With padding compiled out pad_en is 0 and ST_PAD is unreachable.
                    if (s_last) state_d = (pad_en && (cnt_inc < min_c)) ? ST_PAD : ST_FCS;
                end
            end
            ST_PAD: if (load) begin
                m_valid_d = 1'b1;
                m_last_d  = 1'b0;
                m_data_d  = '0;
                crc_d     = crc_next;
                cnt_d     = cnt_inc;
                state_d   = (cnt_inc >= min_c) ? ST_FCS : ST_PAD;
            end
            ST_FCS: if (load) begin
                if (m_valid_q && m_last_q) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    m_data_d  = '0;
                    done_d    = 1'b1;
                    ovf_d     = err_q;
                    state_d   = ST_IDLE;
                end else begin
                    m_valid_d = 1'b1;
                    m_data_d  = fcs_byte;
                    m_last_d  = (fcs_idx_q == 2'd3);
                    fcs_idx_d = fcs_idx_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            crc_q     <= crc_init;
            fcs_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            fcs_idx_q <= fcs_idx_d;
        end
    end

    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign m_last       = m_last_q;
    assign frame_done   = done_q;
    assign oversize_err = ovf_q;
    assign byte_cnt     = cnt_q;

endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// tb_eth_tx_fcs_ctrl: randomized self-checking bench against a reflected-CRC frame model.
module tb_eth_tx_fcs_ctrl;

    localparam int MIN_FRAME = 60;
    localparam int MAX_FRAME = 1514;
`ifdef ETH_TX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic        frame_done;
    logic        oversize_err;
    logic [11:0] byte_cnt;

    always #5 clk = ~clk;

    eth_tx_fcs_ctrl #(.MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_last       (m_last),
        .m_ready      (m_ready),
        .frame_done   (frame_done),
        .oversize_err (oversize_err),
        .byte_cnt     (byte_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] in_q[$];
    bit         in_last_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] out_q[$];
    int         exp_cnt[$];
    int         done_cyc[$];
    int         start_cyc[$];
    int         cnt_at_done[$];
    int         exp_ovf = 0;
    int         nframes = 0;
    int         cyc = 0;
    int         dones, ovfs, first_out_cyc, last_out_cyc;

    // Model: payload, zero pad to MIN_FRAME when padding is built in, then the
    // standard reflected CRC-32 (0xEDB88320) sent LSB first with m_last on the 4th byte.
    task automatic add_frame(input int n, input int kind);
        string      s = "123456789";
        logic [7:0] f[$];
        logic [31:0] c;
        int         len;
        for (int i = 0; i < n; i++) begin
            f.push_back(kind == 0 ? s[i % 9] : 8'($urandom));
            in_q.push_back(f[i]);
            in_last_q.push_back(i == n - 1);
        end
        len = (PAD && n < MIN_FRAME) ? MIN_FRAME : n;
        while (f.size() < len) f.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        foreach (f[i]) begin
            c ^= {24'h0, f[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        foreach (f[i]) exp_q.push_back({1'b0, f[i]});
        for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, 8'(c >> (8 * k))});
        exp_cnt.push_back(len > 4095 ? 4095 : len);
        if (n > MAX_FRAME) exp_ovf++;
        nframes++;
    endtask

    task automatic run(input int stall_pct, input int rst_at);
        int budget = 20000;
        int acc = 0;
        int mism = 0;
        int nf = nframes;
        int n_exp = exp_q.size();
        bit new_frame = 1'b1;
        dones = 0;
        ovfs = 0;
        first_out_cyc = -1;
        last_out_cyc = -1;
        out_q.delete();
        done_cyc.delete();
        start_cyc.delete();
        cnt_at_done.delete();
        while (dones < nframes && budget > 0) begin
            @(negedge clk);
            cyc++;
            budget--;
            if (frame_done) begin
                dones++;
                done_cyc.push_back(cyc);
                cnt_at_done.push_back(int'(byte_cnt));
            end
            if (oversize_err && frame_done) ovfs++;
            if (rst_at >= 0 && acc == rst_at) begin
                rst = 1'b1;
                s_valid = 1'b0;
                s_last = 1'b0;
                @(negedge clk);
                cyc++;
                chk("rst_mid_m_valid", m_valid, 0);
                chk("rst_mid_s_ready", s_ready, 0);
                chk("rst_mid_byte_cnt", byte_cnt, 0);
                chk("rst_mid_m_data", m_data, 0);
                chk("rst_mid_frame_done", frame_done, 0);
                rst = 1'b0;
                in_q.delete();
                in_last_q.delete();
                exp_q.delete();
                exp_cnt.delete();
                nframes = 0;
                exp_ovf = 0;
                return;
            end
            m_ready = ($urandom_range(99) >= stall_pct);
            s_valid = in_q.size() > 0;
            s_data = s_valid ? in_q[0] : 8'h00;
            s_last = s_valid && in_last_q[0];
            #1;
            if (s_valid && s_ready) begin
                if (new_frame) start_cyc.push_back(cyc);
                new_frame = s_last;
                void'(in_q.pop_front());
                void'(in_last_q.pop_front());
                acc++;
            end
            if (m_valid && m_ready) begin
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                out_q.push_back({m_last, m_data});
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        chk("timeout", budget > 0, 1);
        chk("done_count", dones, nf);
        chk("oversize_count", ovfs, exp_ovf);
        chk("out_len", out_q.size(), n_exp);
        for (int i = 0; i < out_q.size() && i < n_exp; i++)
            if (out_q[i] !== exp_q[i]) mism++;
        chk("out_bytes_mismatched", mism, 0);
        for (int i = 0; i < nf; i++)
            chk("byte_cnt_at_done", i < cnt_at_done.size() ? cnt_at_done[i] : -1, exp_cnt[i]);
        if (stall_pct == 0 && nf == 1)
            chk("frame_cycles", last_out_cyc - first_out_cyc + 1, n_exp);
        exp_q.delete();
        exp_cnt.delete();
        nframes = 0;
        exp_ovf = 0;
    endtask

    function automatic logic [31:0] last_fcs();
        int n = out_q.size();
        if (n < 4) return 32'h0;
        return {out_q[n-1][7:0], out_q[n-2][7:0], out_q[n-3][7:0], out_q[n-4][7:0]};
    endfunction

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_last", m_last, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_oversize_err", oversize_err, 0);
        chk("reset_s_ready", s_ready, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_byte_cnt", byte_cnt, 0);
        rst = 1'b0;

        add_frame(9, 0);
        run(0, -1);
`ifndef ETH_TX_PAD_EN
        chk("fcs_123456789", last_fcs(), 32'hCBF4_3926);
`endif
        add_frame(14, 1);
        run(0, -1);
        add_frame(14, 1);
        run(40, -1);
        add_frame(100, 1);
        run(30, -1);
        add_frame(1515, 1);
        run(0, -1);

        add_frame(40, 1);
        run(0, 20);
        add_frame(9, 0);
        run(20, -1);
`ifndef ETH_TX_PAD_EN
        chk("fcs_after_reset", last_fcs(), 32'hCBF4_3926);
`endif

        add_frame(9, 0);
        add_frame(5, 1);
        run(0, -1);
        chk("back_to_back_start",
            (start_cyc.size() > 1 && done_cyc.size() > 0) ? start_cyc[1] - done_cyc[0] : 0, 1);

        repeat (4) add_frame($urandom_range(1, 80), 1);
        add_frame(1, 1);
        run(25, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
